csr_file: RTL
=============

Name: csr_file

Overview:
- Machine-mode CSR register file for the 16-bit pipelined core.
- Responder end of the interrupt CSR interface. It accepts the interrupt controller's entry/return writes (int_we, int_mepc, int_mcause, int_mstatus) and the EX-stage CSR-instruction writes.
- Supplies mtvec/mepc/mstatus and global_int_en back to the interrupt controller.
- Runs a free-running 32-bit cycle counter readable as two 16-bit CSRs.

Parameters:
- DW, 16, data width of every CSR and bus.
- AW, 12, CSR address width.
- MTVEC_RST, 16'h0010, reset value of mtvec (trap entry).
- MSTATUS_RST, 16'h0000, reset value of mstatus.

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset
- ex_we  in  1  EX-stage CSR write enable
- ex_waddr  in  AW  EX-stage CSR write address
- ex_wdata  in  DW  EX-stage CSR write data
- ex_raddr  in  AW  EX-stage CSR read address
- ex_rdata  out  DW  read data, combinational from ex_raddr
- int_we  in  3  interrupt-controller write enables: [0]=mstatus, [1]=mcause, [2]=mepc
- int_mepc  in  DW  mepc write data
- int_mcause  in  DW  mcause write data
- int_mstatus  in  DW  mstatus write data
- int_flag  in  8  raw interrupt lines, visible in mip; bit7 = timer
- csr_mtvec  out  DW  registered mtvec
- csr_mepc  out  DW  registered mepc
- csr_mstatus  out  DW  registered mstatus
- global_int_en  out  1  mstatus[3] (MIE) AND mie[7] (MTIE)

Behaviour:
- Reset (rst_n asynchronous, active-low; clock clk):
  - mstatus=MSTATUS_RST, mtvec=MTVEC_RST.
  - mie, mscratch, mepc, mcause, mcycle = 0.
  - Hence csr_mstatus=0, csr_mepc=0, csr_mtvec=MTVEC_RST, global_int_en=0, ex_rdata=0 for any address with zero state.
- Address map:
  - 0x300 mstatus
  - 0x304 mie
  - 0x305 mtvec
  - 0x340 mscratch
  - 0x341 mepc
  - 0x342 mcause
  - 0x344 mip, read-only = {8'h00, int_flag}
  - 0xB00 mcycle[15:0]
  - 0xB80 mcycle[31:16]
  - Unmapped: reads 0, writes ignored.
  - Writes to mip are ignored.
- Writes take effect on the rising clk edge; updated value is visible on outputs the cycle after.
- Read:
  - ex_rdata is combinational from the current register state.
  - No write-to-read bypass: a same-cycle write to ex_raddr returns the old value.
- Priority: for any CSR targeted by both int_we and ex_we in the same cycle, the interrupt write wins and the EX write to that CSR is dropped. EX writes to other CSRs in the same cycle still complete.
- int_we bits are independent. 3'b111 (trap entry) writes all three CSRs. 3'b001 (mret) writes mstatus only.
- mcycle:
  - 32-bit, increments by 1 every cycle; wraps 0xFFFF_FFFF -> 0.
  - Carry from low into high half occurs within the same cycle.
  - An EX write to a half loads that half with ex_wdata and suppresses the increment for the whole counter that cycle; the other half holds.
- global_int_en is combinational from the mstatus/mie registers, so it drops the cycle after a trap-entry write clears MIE.
- int_flag is sampled only for the mip read; no latching or pending logic lives in this block.
- Reset mid-operation: all registers return to reset values immediately (asynchronous). Any pending write in that cycle is discarded.

Decomposition:
- Shared package/header holds:
  - CSR address constants (CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE, CSR_MIP, CSR_MCYCLE, CSR_MCYCLEH).
  - Bit positions MSTATUS_MIE=3, MSTATUS_MPIE=7, MIE_MTIE=7.
  - int_we bit indices (INT_WE_MSTATUS=0, INT_WE_MCAUSE=1, INT_WE_MEPC=2).
- One natural sub-module: csr_cycle_counter. It implements the 32-bit counter with split 16-bit half-writes and increment suppression.

Test Plan:
1. Reset release → csr_mtvec=16'h0010, csr_mstatus=0, global_int_en=0; ex_raddr=0xB00 reads 1 one cycle after reset release.
2. EX writes mstatus=16'h0008 then mie=16'h0080 → global_int_en=1 the cycle after the second write. Clearing either bit → global_int_en=0.
3. int_we=3'b111 with int_mepc=16'h0123, int_mcause=16'h0004, int_mstatus=16'h0000 → next cycle csr_mepc=16'h0123, mcause reads 4, global_int_en=0. Then int_we=3'b001, int_mstatus=16'h0088 → mstatus=16'h0088, mepc unchanged.
4. Same cycle: int_we=3'b100 with int_mepc=16'h0050, and ex_we to 0x341 with 16'h0099 → mepc=16'h0050. Also same cycle: int_we=3'b100 and ex_we to 0x340 with 16'hBEEF → mepc=16'h0050 and mscratch=16'hBEEF.
5. EX writes 0xB00=16'hFFFF then 0xB80=16'hFFFF → counter reaches 0xFFFF_FFFF, then wraps. Reads of 0xB00/0xB80 return 0/0 on the wrap cycle, then low=1 the next cycle.
6. Write 0x344 and 0x7C0 with 16'h1234 → both reads unaffected (mip reads {8'h00, int_flag} with int_flag=8'h80 → 16'h0080; 0x7C0 reads 0). Assert rst_n mid-write → all CSRs at reset values.

Source files
------------

// File: rtl/csr_file_pkg.sv
// Shared constants for the machine-mode CSR file: CSR addresses, status/enable
// bit positions and interrupt-controller write-enable bit indices.
package csr_file_pkg;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH  = 12'hB80;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int MIE_MTIE     = 7;

  localparam int INT_WE_MSTATUS = 0;
  localparam int INT_WE_MCAUSE  = 1;
  localparam int INT_WE_MEPC    = 2;

endpackage

// File: rtl/csr_cycle_counter.sv
// Free-running 2*DW-bit cycle counter with independently writable halves.
// Any half-write freezes the whole counter for that cycle.
module csr_cycle_counter #(
  parameter int DW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we_lo,
  input  logic            we_hi,
  input  logic [DW-1:0]   wdata,
  output logic [2*DW-1:0] count
);

  localparam logic [2*DW-1:0] ONE = {{(2*DW-1){1'b0}}, 1'b1};

  logic [2*DW-1:0] r_count;

  // Full-width add so the low-to-high carry lands in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (we_lo || we_hi) begin
      if (we_lo) r_count[DW-1:0]    <= wdata;
      if (we_hi) r_count[2*DW-1:DW] <= wdata;
    end else begin
      r_count <= r_count + ONE;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file: EX-stage CSR read/write port, interrupt-controller
// entry/return write port, and a 32-bit cycle counter.
module csr_file
  import csr_file_pkg::*;
#(
  parameter int             DW          = 16,
  parameter int             AW          = 12,
  parameter logic [DW-1:0]  MTVEC_RST   = 16'h0010,
  parameter logic [DW-1:0]  MSTATUS_RST = 16'h0000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ex_we,
  input  logic [AW-1:0] ex_waddr,
  input  logic [DW-1:0] ex_wdata,
  input  logic [AW-1:0] ex_raddr,
  output logic [DW-1:0] ex_rdata,
  input  logic [2:0]    int_we,
  input  logic [DW-1:0] int_mepc,
  input  logic [DW-1:0] int_mcause,
  input  logic [DW-1:0] int_mstatus,
  input  logic [7:0]    int_flag,
  output logic [DW-1:0] csr_mtvec,
  output logic [DW-1:0] csr_mepc,
  output logic [DW-1:0] csr_mstatus,
  output logic          global_int_en
);

  logic [DW-1:0] r_mstatus;
  logic [DW-1:0] r_mie;
  logic [DW-1:0] r_mtvec;
  logic [DW-1:0] r_mscratch;
  logic [DW-1:0] r_mepc;
  logic [DW-1:0] r_mcause;

  logic          w_ex_mstatus;
  logic          w_ex_mie;
  logic          w_ex_mtvec;
  logic          w_ex_mscratch;
  logic          w_ex_mepc;
  logic          w_ex_mcause;
  logic          w_ex_mcycle;
  logic          w_ex_mcycleh;
  logic [2*DW-1:0] w_mcycle;

  assign w_ex_mstatus  = ex_we && (ex_waddr == AW'(CSR_MSTATUS));
  assign w_ex_mie      = ex_we && (ex_waddr == AW'(CSR_MIE));
  assign w_ex_mtvec    = ex_we && (ex_waddr == AW'(CSR_MTVEC));
  assign w_ex_mscratch = ex_we && (ex_waddr == AW'(CSR_MSCRATCH));
  assign w_ex_mepc     = ex_we && (ex_waddr == AW'(CSR_MEPC));
  assign w_ex_mcause   = ex_we && (ex_waddr == AW'(CSR_MCAUSE));
  assign w_ex_mcycle   = ex_we && (ex_waddr == AW'(CSR_MCYCLE));
  assign w_ex_mcycleh  = ex_we && (ex_waddr == AW'(CSR_MCYCLEH));

  // Interrupt-controller writes take priority per CSR; EX writes elsewhere proceed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mstatus  <= MSTATUS_RST;
      r_mie      <= '0;
      r_mtvec    <= MTVEC_RST;
      r_mscratch <= '0;
      r_mepc     <= '0;
      r_mcause   <= '0;
    end else begin
      if (int_we[INT_WE_MSTATUS]) r_mstatus <= int_mstatus;
      else if (w_ex_mstatus)      r_mstatus <= ex_wdata;

      if (int_we[INT_WE_MEPC])    r_mepc <= int_mepc;
      else if (w_ex_mepc)         r_mepc <= ex_wdata;

      if (int_we[INT_WE_MCAUSE])  r_mcause <= int_mcause;
      else if (w_ex_mcause)       r_mcause <= ex_wdata;

      if (w_ex_mie)      r_mie      <= ex_wdata;
      if (w_ex_mtvec)    r_mtvec    <= ex_wdata;
      if (w_ex_mscratch) r_mscratch <= ex_wdata;
    end
  end

  csr_cycle_counter #(
    .DW (DW)
  ) u_cycle_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .we_lo (w_ex_mcycle),
    .we_hi (w_ex_mcycleh),
    .wdata (ex_wdata),
    .count (w_mcycle)
  );

  always_comb begin
    ex_rdata = '0;
    case (ex_raddr)
      AW'(CSR_MSTATUS):  ex_rdata = r_mstatus;
      AW'(CSR_MIE):      ex_rdata = r_mie;
      AW'(CSR_MTVEC):    ex_rdata = r_mtvec;
      AW'(CSR_MSCRATCH): ex_rdata = r_mscratch;
      AW'(CSR_MEPC):     ex_rdata = r_mepc;
      AW'(CSR_MCAUSE):   ex_rdata = r_mcause;
      AW'(CSR_MIP):      ex_rdata = DW'(int_flag);
      AW'(CSR_MCYCLE):   ex_rdata = w_mcycle[DW-1:0];
      AW'(CSR_MCYCLEH):  ex_rdata = w_mcycle[2*DW-1:DW];
      default:           ex_rdata = '0;
    endcase
  end

  assign csr_mtvec     = r_mtvec;
  assign csr_mepc      = r_mepc;
  assign csr_mstatus   = r_mstatus;
  assign global_int_en = r_mstatus[MSTATUS_MIE] & r_mie[MIE_MTIE];

endmodule
